// File: rtl/l2_cache_control.sv
// l2_cache_control: request sequencer for the 4-way, 8-set L2 cache (hit/miss, writeback, fill, LRU, counters)
module l2_cache_control #(
    parameter int NUM_WAYS = 4,
    parameter int CNT_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mem_read,
    input  logic                          mem_write,
    output logic                          mem_resp,
    input  logic                          hit,
    input  logic [$clog2(NUM_WAYS)-1:0]   hit_way,
    input  logic [$clog2(NUM_WAYS)-1:0]   lru_way,
    input  logic                          lru_dirty,
    output logic                          pmem_read,
    output logic                          pmem_write,
    input  logic                          pmem_resp,
    output logic [$clog2(NUM_WAYS)-1:0]   way_sel,
    output logic                          load_data,
    output logic                          load_tag,
    output logic                          set_dirty,
    output logic                          clr_dirty,
    output logic                          data_src,
    output logic                          addr_sel,
    output logic                          lru_load,
    output logic [$clog2(NUM_WAYS)-1:0]   lru_mru,
    output logic [CNT_W-1:0]              hit_cnt,
    output logic [CNT_W-1:0]              miss_cnt
);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMP  = 3'd1;
    localparam logic [2:0] S_WB   = 3'd2;
    localparam logic [2:0] S_FILL = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [WAY_W-1:0] victim_way_q, victim_way_d;
    logic             refill_q, refill_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic             req;

    assign req      = mem_read | mem_write;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

    // Next-state, victim/refill bookkeeping, counters and all array/pmem strobes
    always_comb begin
        state_d      = state_q;
        victim_way_d = victim_way_q;
        refill_d     = refill_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        way_sel      = '0;
        load_data    = 1'b0;
        load_tag     = 1'b0;
        set_dirty    = 1'b0;
        clr_dirty    = 1'b0;
        data_src     = 1'b0;
        addr_sel     = 1'b0;
        lru_load     = 1'b0;
        lru_mru      = '0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d  = S_CMP;
                    refill_d = 1'b0;
                end
            end
            S_CMP: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (hit) begin
                    lru_load  = 1'b1;
                    lru_mru   = hit_way;
                    way_sel   = hit_way;
                    load_data = mem_write;
                    set_dirty = mem_write;
                    if (!refill_q && hit_cnt_q != '1)
                        hit_cnt_d = hit_cnt_q + 1'b1;
                    state_d = S_DONE;
                end else begin
                    victim_way_d = lru_way;
                    if (!refill_q && miss_cnt_q != '1)
                        miss_cnt_d = miss_cnt_q + 1'b1;
                    state_d = lru_dirty ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                pmem_write = 1'b1;
                addr_sel   = 1'b1;
                way_sel    = victim_way_q;
                if (pmem_resp)
                    state_d = S_FILL;
            end
            S_FILL: begin
                pmem_read = 1'b1;
                way_sel   = victim_way_q;
                if (pmem_resp) begin
                    load_data = 1'b1;
                    data_src  = 1'b1;
                    load_tag  = 1'b1;
                    clr_dirty = 1'b1;
                    refill_d  = 1'b1;
                    state_d   = S_CMP;
                end
            end
            S_DONE: begin
                mem_resp = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset is asynchronous so a mid-transfer reset drops pmem strobes at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            victim_way_q <= '0;
            refill_q     <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            victim_way_q <= victim_way_d;
            refill_q     <= refill_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end
endmodule

// File: tb/tb_l2_cache_control.sv
// tb_l2_cache_control: randomized transaction-level check of the L2 sequencer against a scripted reference
module tb_l2_cache_control;
    logic clk = 1'b0;
    logic rst, mem_read, mem_write, hit, lru_dirty, pmem_resp;
    logic [1:0] hit_way, lru_way;
    logic mem_resp, pmem_read, pmem_write, load_data, load_tag, set_dirty, clr_dirty, data_src, addr_sel, lru_load;
    logic [1:0] way_sel, lru_mru;
    logic [15:0] hit_cnt, miss_cnt;
    logic s_mem_resp, s_pmem_read, s_pmem_write, s_load_data, s_load_tag, s_set_dirty, s_clr_dirty, s_data_src, s_addr_sel, s_lru_load;
    logic [1:0] s_way_sel, s_lru_mru;
    logic [3:0] s_hit_cnt, s_miss_cnt;

    localparam logic [13:0] ALL = 14'b11111111111111;
    localparam logic [13:0] STB = 14'b11100111100100;
    localparam logic [13:0] WS  = 14'b00011000000000;
    localparam logic [13:0] DS  = 14'b00000000010000;
    localparam logic [13:0] AS  = 14'b00000000001000;
    localparam logic [13:0] MRU = 14'b00000000000011;

    int checks = 0, failures = 0, cyc = 0, last_ll = -1, hits = 0, misses = 0;
    logic [13:0] out_v, sat_v;

    always #5 clk = ~clk;

    l2_cache_control u_dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit(hit), .hit_way(hit_way), .lru_way(lru_way), .lru_dirty(lru_dirty),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .way_sel(way_sel), .load_data(load_data), .load_tag(load_tag), .set_dirty(set_dirty),
        .clr_dirty(clr_dirty), .data_src(data_src), .addr_sel(addr_sel), .lru_load(lru_load),
        .lru_mru(lru_mru), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Narrow-counter copy so saturation is reached in a short run
    l2_cache_control #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(s_mem_resp),
        .hit(hit), .hit_way(hit_way), .lru_way(lru_way), .lru_dirty(lru_dirty),
        .pmem_read(s_pmem_read), .pmem_write(s_pmem_write), .pmem_resp(pmem_resp),
        .way_sel(s_way_sel), .load_data(s_load_data), .load_tag(s_load_tag), .set_dirty(s_set_dirty),
        .clr_dirty(s_clr_dirty), .data_src(s_data_src), .addr_sel(s_addr_sel), .lru_load(s_lru_load),
        .lru_mru(s_lru_mru), .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
    );

    assign out_v = {mem_resp, pmem_read, pmem_write, way_sel, load_data, load_tag, set_dirty, clr_dirty, data_src, addr_sel, lru_load, lru_mru};
    assign sat_v = {s_mem_resp, s_pmem_read, s_pmem_write, s_way_sel, s_load_data, s_load_tag, s_set_dirty, s_clr_dirty, s_data_src, s_addr_sel, s_lru_load, s_lru_mru};

    function automatic logic [13:0] ov(input logic r, pr, pw, input logic [1:0] ws, input logic ld, lt, sd, cd, ds, as, ll, input logic [1:0] mru);
        return {r, pr, pw, ws, ld, lt, sd, cd, ds, as, ll, mru};
    endfunction

    function automatic int cap(input int n, input int w);
        return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called just after a negedge with inputs applied; checks outputs, then advances one cycle
    task automatic step(input string tag, input logic [13:0] ev, input logic [13:0] m);
        #2;
        check(tag, 32'(out_v & m), 32'(ev & m));
        check({tag, "_n"}, 32'(sat_v & m), 32'(ev & m));
        if (lru_load) begin
            if (last_ll >= 0) check("lru_gap", 32'(cyc - last_ll >= 3), 32'd1);
            last_ll = cyc;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_counts();
        check("hit_cnt", 32'(hit_cnt), 32'(cap(hits, 16)));
        check("miss_cnt", 32'(miss_cnt), 32'(cap(misses, 16)));
        check("hit_cnt_n", 32'(s_hit_cnt), 32'(cap(hits, 4)));
        check("miss_cnt_n", 32'(s_miss_cnt), 32'(cap(misses, 4)));
    endtask

    task automatic txn(input logic wr, fh, input logic [1:0] hw, lw, input logic dt, input int ww, fw, input logic drop);
        logic [1:0] victim;
        logic [13:0] wm;
        logic live;
        live = 1'b1;
        wm = STB | MRU;
        if (wr) wm = wm | WS | DS;
        mem_write = wr;
        mem_read = wr ? 1'($urandom) : 1'b1;
        hit = 1'($urandom); hit_way = 2'($urandom); lru_way = 2'($urandom); lru_dirty = 1'($urandom);
        pmem_resp = 1'($urandom);
        step("idle", 14'd0, ALL);
        pmem_resp = 1'b0;
        hit = fh; hit_way = hw; lru_way = lw; lru_dirty = dt;
        if (fh) begin
            hits++;
            step("cmp_hit", ov(0, 0, 0, hw, wr, 0, wr, 0, 0, 0, 1, hw), wm);
        end else begin
            misses++;
            victim = lw;
            step("cmp_miss", 14'd0, STB);
            if (dt) begin
                for (int i = 0; i < ww; i++) begin
                    pmem_resp = (i == ww - 1);
                    lru_way = 2'($urandom); hit = 1'($urandom); hit_way = 2'($urandom);
                    if (drop && i == 0) begin mem_read = 1'b0; mem_write = 1'b0; live = 1'b0; end
                    step("wb", ov(0, 0, 1, victim, 0, 0, 0, 0, 0, 1, 0, 0), STB | WS | AS);
                end
            end
            for (int i = 0; i < fw; i++) begin
                logic last;
                last = (i == fw - 1);
                pmem_resp = last;
                lru_way = 2'($urandom); hit = 1'($urandom); hit_way = 2'($urandom);
                if (drop && !dt && i == 0) begin mem_read = 1'b0; mem_write = 1'b0; live = 1'b0; end
                step("fill", ov(0, 1, 0, victim, last, last, 0, last, last, 0, 0, 0), STB | WS | AS | (last ? DS : 14'd0));
            end
            pmem_resp = 1'b0;
            hit = 1'b1; hit_way = victim; lru_way = 2'($urandom);
            if (!live) begin
                step("recmp_drop", 14'd0, STB);
                mem_read = 1'b0; mem_write = 1'b0;
                step("after_drop", 14'd0, ALL);
                check_counts();
                return;
            end
            step("recmp", ov(0, 0, 0, victim, wr, 0, wr, 0, 0, 0, 1, victim), wm);
        end
        hit = 1'($urandom); hit_way = 2'($urandom); lru_way = 2'($urandom);
        step("done", ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), STB);
        mem_read = 1'b0; mem_write = 1'b0;
        check_counts();
    endtask

    initial begin
        rst = 1'b1;
        {mem_read, mem_write, hit, lru_dirty, pmem_resp} = '0;
        hit_way = 2'd0; lru_way = 2'd0;
        @(negedge clk);
        #2;
        check("rst_outs", 32'(out_v), 32'd0);
        check_counts();
        @(negedge clk);
        rst = 1'b0;
        txn(1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1, 1, 1'b0);
        txn(1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 1, 1, 1'b0);
        txn(1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1, 4, 1'b0);
        txn(1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 3, 2, 1'b0);
        txn(1'b0, 1'b0, 2'd0, 2'd2, 1'b1, 2, 2, 1'b1);
        for (int n = 0; n < 20; n++)
            txn(1'b0, 1'b1, 2'($urandom), 2'd0, 1'b0, 1, 1, 1'b0);
        for (int n = 0; n < 60; n++) begin
            logic fh, dt;
            fh = ($urandom % 4) != 0;
            dt = 1'($urandom);
            txn(1'($urandom), fh, 2'($urandom), 2'($urandom), dt, $urandom_range(1, 4), $urandom_range(1, 4), !fh && ($urandom % 5 == 0));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                pmem_resp = 1'($urandom);
                step("gap", 14'd0, ALL);
            end
            pmem_resp = 1'b0;
        end
        mem_read = 1'b1; mem_write = 1'b0;
        step("idle_r", 14'd0, ALL);
        hit = 1'b0; lru_way = 2'd2; lru_dirty = 1'b0;
        misses++;
        step("cmp_r", 14'd0, STB);
        step("fill_r", ov(0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0), STB | WS);
        #2 rst = 1'b1;
        #1;
        hits = 0; misses = 0; last_ll = -1;
        check("rst_mid_fill", 32'(out_v), 32'd0);
        check_counts();
        @(negedge clk);
        rst = 1'b0; mem_read = 1'b0; pmem_resp = 1'b1;
        step("post_rst_resp", 14'd0, ALL);
        pmem_resp = 1'b0;
        step("post_rst_idle", 14'd0, ALL);
        check_counts();
        txn(1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 1, 1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
